// File: rtl/hot_addr_pull.sv
// Host-memory hot-page ring reader: polls 64B lines over AXI4, accepts a line only when
// every entry carries the expected phase bit, and streams the nonzero PFNs out.
module hot_addr_pull #(
  parameter int unsigned RING_SIZE = 65536,
  parameter int unsigned POLL_GAP  = 64,
  parameter logic [11:0] AXI_ID    = 12'h000
) (
  input  logic         axi4_mm_clk,
  input  logic         axi4_mm_rst_n,
  input  logic         enable,
  input  logic [63:0]  ring_base,
  input  logic [5:0]   csr_aruser,
  output logic [11:0]  hapl_arid,
  output logic [63:0]  hapl_araddr,
  output logic [5:0]   hapl_aruser,
  output logic         hapl_arvalid,
  input  logic         hapl_arready,
  input  logic [11:0]  hapl_rid,
  input  logic [511:0] hapl_rdata,
  input  logic [1:0]   hapl_rresp,
  input  logic         hapl_rlast,
  input  logic         hapl_rvalid,
  output logic         hapl_rready,
  output logic         pfn_valid,
  output logic [30:0]  pfn,
  input  logic         pfn_ready,
  output logic [63:0]  consumed_count,
  output logic [15:0]  rd_err_cnt
);

  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned LINE_W    = 512;
  localparam int unsigned PFN_W     = 31;
  localparam int unsigned ENTRIES   = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned ERR_W     = 16;
  localparam int unsigned USER_W    = 6;
  localparam int unsigned NUM_LINES = RING_SIZE / 64;
  localparam int unsigned OFF_W     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int unsigned GAP_W     = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_AR      = 3'd1,
    ST_R       = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_BACKOFF = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [USER_W-1:0]   aruser_q, aruser_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [OFF_W-1:0]    offset_q, offset_d;
  logic                phase_q, phase_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                pfn_valid_q, pfn_valid_d;
  logic [PFN_W-1:0]    pfn_q, pfn_d;
  logic [63:0]         consumed_q, consumed_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

  logic                phase_ok_c;
  logic                drain_adv_c;
  logic                line_done_c;
  logic                gap_done_c;
  logic [PFN_W-1:0]    nxt_pfn_c;
  logic                unused_rid_rlast;

  assign unused_rid_rlast = ^{hapl_rid, hapl_rlast};

  function automatic logic [PFN_W-1:0] entry_pfn(input logic [LINE_W-1:0] line,
                                                 input logic [IDX_W-1:0]  idx);
    return line[{idx, 5'd0} +: PFN_W];
  endfunction

  // Line is fresh only if every entry's bit 31 matches the expected phase.
  always_comb begin
    phase_ok_c = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (line_q[32*i + 31] != phase_q) phase_ok_c = 1'b0;
    end
  end

  assign drain_adv_c = !pfn_valid_q || pfn_ready;
  assign line_done_c = (state_q == ST_DRAIN) && drain_adv_c && (idx_q == IDX_W'(ENTRIES - 1));
  assign gap_done_c  = (gap_cnt_q == GAP_W'(POLL_GAP - 1));

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (enable && (ring_base != '0)) state_d = ST_AR;
      ST_AR:      if (hapl_arready) state_d = ST_R;
      ST_R:       if (hapl_rvalid) state_d = ST_CHECK;
      ST_CHECK:   state_d = ((rresp_q == 2'b00) && phase_ok_c) ? ST_DRAIN : ST_BACKOFF;
      ST_BACKOFF: if (gap_done_c) state_d = enable ? ST_AR : ST_IDLE;
      ST_DRAIN:   if (line_done_c) state_d = enable ? ST_AR : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    araddr_d    = araddr_q;
    aruser_d    = aruser_q;
    arvalid_d   = (state_d == ST_AR);
    rready_d    = (state_d == ST_R);
    line_d      = line_q;
    rresp_d     = rresp_q;
    offset_d    = offset_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    gap_cnt_d   = gap_cnt_q;
    pfn_valid_d = pfn_valid_q;
    pfn_d       = pfn_q;
    consumed_d  = consumed_q;
    err_cnt_d   = err_cnt_q;
    nxt_pfn_c   = entry_pfn(line_q, idx_q + IDX_W'(1));

    case (state_q)
      ST_R: begin
        if (hapl_rvalid) begin
          line_d  = hapl_rdata;
          rresp_d = hapl_rresp;
        end
      end
      ST_CHECK: begin
        gap_cnt_d = '0;
        if (rresp_q != 2'b00) begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
        end else if (phase_ok_c) begin
          idx_d       = '0;
          pfn_d       = entry_pfn(line_q, '0);
          pfn_valid_d = (entry_pfn(line_q, '0) != '0);
        end
      end
      ST_BACKOFF: gap_cnt_d = gap_cnt_q + GAP_W'(1);
      ST_DRAIN: begin
        // Zero entries still take one cycle with pfn_valid low.
        if (drain_adv_c) begin
          if (idx_q == IDX_W'(ENTRIES - 1)) begin
            pfn_valid_d = 1'b0;
            offset_d    = (offset_q == OFF_W'(NUM_LINES - 1)) ? '0 : offset_q + OFF_W'(1);
            phase_d     = ~phase_q;
            consumed_d  = consumed_q + 64'd1;
          end else begin
            idx_d       = idx_q + IDX_W'(1);
            pfn_d       = nxt_pfn_c;
            pfn_valid_d = (nxt_pfn_c != '0);
          end
        end
      end
      default: ;
    endcase

    // Address and user are latched on AR entry and held until the handshake.
    if ((state_d == ST_AR) && (state_q != ST_AR)) begin
      araddr_d = ring_base + (ADDR_W'(offset_d) << 6);
      aruser_d = csr_aruser;
    end
  end

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      araddr_q    <= '0;
      aruser_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      line_q      <= '0;
      rresp_q     <= '0;
      offset_q    <= '0;
      phase_q     <= 1'b0;
      idx_q       <= '0;
      gap_cnt_q   <= '0;
      pfn_valid_q <= 1'b0;
      pfn_q       <= '0;
      consumed_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      araddr_q    <= araddr_d;
      aruser_q    <= aruser_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      line_q      <= line_d;
      rresp_q     <= rresp_d;
      offset_q    <= offset_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      gap_cnt_q   <= gap_cnt_d;
      pfn_valid_q <= pfn_valid_d;
      pfn_q       <= pfn_d;
      consumed_q  <= consumed_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign hapl_arid      = AXI_ID;
  assign hapl_araddr    = araddr_q;
  assign hapl_aruser    = aruser_q;
  assign hapl_arvalid   = arvalid_q;
  assign hapl_rready    = rready_q;
  assign pfn_valid      = pfn_valid_q;
  assign pfn            = pfn_q;
  assign consumed_count = consumed_q;
  assign rd_err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_hot_addr_pull.sv
// Scoreboard bench for hot_addr_pull: an AXI read slave serves queued lines and the
// expected address/PFN stream is derived from a small ring model.
`timescale 1ns/1ps
module tb_hot_addr_pull;

  localparam int unsigned RING_SIZE = 128;
  localparam int unsigned POLL_GAP  = 4;
  localparam logic [11:0] AXI_ID    = 12'h5A5;
  localparam logic [63:0] BASE      = 64'h0000_0012_3456_7000;
  localparam logic [5:0]  USER      = 6'h2B;

  logic         clk, rst_n;
  logic         enable;
  logic [63:0]  ring_base;
  logic [5:0]   csr_aruser;
  logic [11:0]  hapl_arid;
  logic [63:0]  hapl_araddr;
  logic [5:0]   hapl_aruser;
  logic         hapl_arvalid, hapl_arready;
  logic [11:0]  hapl_rid;
  logic [511:0] hapl_rdata;
  logic [1:0]   hapl_rresp;
  logic         hapl_rlast, hapl_rvalid, hapl_rready;
  logic         pfn_valid, pfn_ready;
  logic [30:0]  pfn;
  logic [63:0]  consumed_count;
  logic [15:0]  rd_err_cnt;

  hot_addr_pull #(.RING_SIZE(RING_SIZE), .POLL_GAP(POLL_GAP), .AXI_ID(AXI_ID)) dut (
    .axi4_mm_clk(clk), .axi4_mm_rst_n(rst_n), .enable(enable), .ring_base(ring_base),
    .csr_aruser(csr_aruser), .hapl_arid(hapl_arid), .hapl_araddr(hapl_araddr),
    .hapl_aruser(hapl_aruser), .hapl_arvalid(hapl_arvalid), .hapl_arready(hapl_arready),
    .hapl_rid(hapl_rid), .hapl_rdata(hapl_rdata), .hapl_rresp(hapl_rresp),
    .hapl_rlast(hapl_rlast), .hapl_rvalid(hapl_rvalid), .hapl_rready(hapl_rready),
    .pfn_valid(pfn_valid), .pfn(pfn), .pfn_ready(pfn_ready),
    .consumed_count(consumed_count), .rd_err_cnt(rd_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic [1:0]   resp;
    logic [63:0]  addr;
    logic         stale;
  } rsp_t;

  rsp_t        rsp_q[$];
  rsp_t        cur;
  bit          cur_v;
  logic [30:0] exp_pfn_q[$];

  int          checks, errors;
  int          cyc, hs_cyc, acc_cnt, stop_at, ready_mode;
  bit          in_rst, r_fire, gap_armed, arv_prev, hold_prev;
  logic [30:0] hold_pfn;

  int          m_off;
  bit          m_phase;
  longint      m_consumed;
  int          m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] make_line(input logic [30:0] base, input logic ph,
                                             input logic [15:0] zero_m, input logic [15:0] flip_m);
    logic [511:0] l;
    l = '0;
    for (int i = 0; i < 16; i++) begin
      l[32*i + 31]  = ph ^ flip_m[i];
      l[32*i +: 31] = zero_m[i] ? 31'd0 : base + 31'(i);
    end
    return l;
  endfunction

  // Ring model: decides freshness from the expected phase and queues the expected outputs.
  task automatic push_line(input logic [511:0] data, input logic [1:0] resp);
    rsp_t r;
    bit   ok;
    r.data = data;
    r.resp = resp;
    r.addr = BASE + 64'(m_off) * 64;
    ok = (resp == 2'b00);
    for (int i = 0; i < 16; i++) if (data[32*i + 31] != m_phase) ok = 0;
    r.stale = !ok;
    if (resp != 2'b00 && m_err != 16'hFFFF) m_err++;
    if (ok) begin
      for (int i = 0; i < 16; i++)
        if (data[32*i +: 31] != 31'd0) exp_pfn_q.push_back(data[32*i +: 31]);
      m_off = (m_off + 1) % (RING_SIZE / 64);
      m_phase = ~m_phase;
      m_consumed++;
    end
    rsp_q.push_back(r);
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || cur_v || hapl_rvalid || exp_pfn_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({"timeout_", tag}, 64'(n < budget), 64'd1);
    repeat (POLL_GAP + 8) @(negedge clk);
  endtask

  // AXI slave, PFN sink and protocol checks, all decided on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!in_rst) begin
        if (r_fire) begin
          hapl_rvalid = 1'b0;
          r_fire = 0;
        end
        if (cur_v && !hapl_rvalid && ($urandom_range(3) != 0)) begin
          hapl_rvalid = 1'b1;
          hapl_rdata  = cur.data;
          hapl_rresp  = cur.resp;
        end
        if (hapl_rvalid && hapl_rready) begin
          r_fire = 1;
          cur_v = 0;
          gap_armed = cur.stale;
          hs_cyc = cyc;
        end

        if (hapl_arvalid && !arv_prev && gap_armed) begin
          check("retry_gap", 64'(cyc - hs_cyc), 64'(POLL_GAP + 2));
          gap_armed = 0;
        end
        arv_prev = hapl_arvalid;
        hapl_arready = (rsp_q.size() > 0) && !cur_v && !hapl_rvalid && ($urandom_range(1) == 1);
        if (hapl_arvalid && hapl_arready) begin
          cur = rsp_q.pop_front();
          cur_v = 1;
          check("araddr", hapl_araddr, cur.addr);
          check("arid", 64'(hapl_arid), 64'(AXI_ID));
          check("aruser", 64'(hapl_aruser), 64'(USER));
        end

        if (hold_prev) begin
          check("pfn_hold_valid", 64'(pfn_valid), 64'd1);
          check("pfn_hold_value", 64'(pfn), 64'(hold_pfn));
        end
        case (ready_mode)
          0:       pfn_ready = 1'b1;
          1:       pfn_ready = 1'($urandom_range(1));
          default: pfn_ready = (acc_cnt < stop_at);
        endcase
        hold_prev = pfn_valid && !pfn_ready;
        hold_pfn  = pfn;
        if (pfn_valid && pfn_ready) begin
          acc_cnt++;
          if (exp_pfn_q.size() == 0) check("pfn_extra", 64'(exp_pfn_q.size()), 64'd1);
          else check("pfn", 64'(pfn), 64'(exp_pfn_q.pop_front()));
        end
      end
    end
  end

  task automatic reset_bench();
    rsp_q.delete();
    exp_pfn_q.delete();
    cur_v = 0; r_fire = 0; gap_armed = 0; arv_prev = 0; hold_prev = 0;
    hapl_rvalid = 1'b0; hapl_arready = 1'b0;
    m_off = 0; m_phase = 0; m_consumed = 0; m_err = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_arvalid"}, 64'(hapl_arvalid), 64'd0);
    check({tag, "_rready"}, 64'(hapl_rready), 64'd0);
    check({tag, "_pfn_valid"}, 64'(pfn_valid), 64'd0);
    check({tag, "_pfn"}, 64'(pfn), 64'd0);
    check({tag, "_consumed"}, consumed_count, 64'd0);
    check({tag, "_rd_err"}, 64'(rd_err_cnt), 64'd0);
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; cyc = 0; hs_cyc = 0; acc_cnt = 0; stop_at = 0; ready_mode = 0;
    in_rst = 1; rst_n = 1'b0;
    enable = 1'b0; ring_base = '0; csr_aruser = USER;
    hapl_rid = 12'h0; hapl_rdata = '0; hapl_rresp = 2'b00; hapl_rlast = 1'b1;
    pfn_ready = 1'b1;
    reset_bench();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    in_rst = 0;
    @(negedge clk);
    enable = 1'b1;
    ring_base = BASE;

    // Fresh line 0, phase 0, always ready
    push_line(make_line(31'h100, m_phase, 16'h0000, 16'h0000), 2'b00);
    wait_quiet(2000, "t1");
    check("t1_consumed", consumed_count, 64'(m_consumed));

    // One entry with the wrong phase: line is stale and re-polled
    push_line(make_line(31'h200, m_phase, 16'h0000, 16'h0080), 2'b00);
    wait_quiet(2000, "t2");
    check("t2_consumed", consumed_count, 64'(m_consumed));

    // Same offset now fresh, entries 3 and 9 zero, random backpressure; wraps the ring
    ready_mode = 1;
    push_line(make_line(31'h300, m_phase, 16'h0208, 16'h0000), 2'b00);
    wait_quiet(4000, "t3");
    check("t3_consumed", consumed_count, 64'(m_consumed));

    // Back at offset 0 expecting phase 0: phase-1 line is stale, phase-0 line accepted
    ready_mode = 0;
    push_line(make_line(31'h400, ~m_phase, 16'h0000, 16'h0000), 2'b00);
    push_line(make_line(31'h500, m_phase, 16'h0000, 16'h0000), 2'b00);
    wait_quiet(4000, "t4");
    check("t4_consumed", consumed_count, 64'(m_consumed));

    // Error response is counted and retried at the same address
    push_line(make_line(31'h600, m_phase, 16'h0000, 16'h0000), 2'b10);
    wait_quiet(2000, "t5a");
    check("t5_rd_err", 64'(rd_err_cnt), 64'(m_err));
    push_line(make_line(31'h680, m_phase, 16'h0000, 16'h0000), 2'b00);
    wait_quiet(2000, "t5b");
    check("t5_consumed", consumed_count, 64'(m_consumed));

    // Stall at entry 5 of a fresh line, then reset mid-drain
    ready_mode = 2;
    stop_at = acc_cnt + 5;
    push_line(make_line(31'h700, m_phase, 16'h0000, 16'h0000), 2'b00);
    n = 0;
    while (!(acc_cnt == stop_at && pfn_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_t6", 64'(n < 2000), 64'd1);
    repeat (3) @(negedge clk);
    check("t6_stall_pfn", 64'(pfn), 64'h705);
    #2;
    rst_n = 1'b0;
    in_rst = 1;
    #1;
    check_zero_outputs("t6_async_reset");
    enable = 1'b0;
    reset_bench();
    ready_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    in_rst = 0;
    @(negedge clk);
    enable = 1'b1;
    push_line(make_line(31'h800, m_phase, 16'h0000, 16'h0000), 2'b00);
    wait_quiet(2000, "t6");
    check("t6_consumed", consumed_count, 64'(m_consumed));
    check("t6_rd_err", 64'(rd_err_cnt), 64'(m_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
